// File: rtl/uart_baud_gen_frac_if.sv
// ----------------------------------------------------------------------------
// uart_baud_gen_frac_if
//
// Purpose:
//   Bundles the control and tick signals of the fractional baud generator.
//   The master side (peripheral bus / UART core) enables the generator,
//   writes the divisor and requests tx phase realignment. The slave side
//   (the generator) returns the active divisor and the two clock-enable
//   ticks.
//
// Signals:
//   en          master -> slave  generator enable
//   div_wr      master -> slave  divisor write strobe
//   div_wdata   master -> slave  {int, frac} divisor to write
//   tx_restart  master -> slave  realign the tx tick phase
//   div_rdata   slave -> master  currently active divisor
//   rxclk_en    slave -> master  1-cycle oversample tick
//   txclk_en    slave -> master  1-cycle bit tick
//
// DIV_WIDTH and FRAC_BITS must match the generator instance using it.
// ----------------------------------------------------------------------------
interface uart_baud_gen_frac_if #(
    parameter int DIV_WIDTH = 16,
    parameter int FRAC_BITS = 4
);

    logic                           en;
    logic                           div_wr;
    logic [DIV_WIDTH+FRAC_BITS-1:0] div_wdata;
    logic                           tx_restart;
    logic [DIV_WIDTH+FRAC_BITS-1:0] div_rdata;
    logic                           rxclk_en;
    logic                           txclk_en;

    // Bus / UART side
    modport master (
        output en,
        output div_wr,
        output div_wdata,
        output tx_restart,
        input  div_rdata,
        input  rxclk_en,
        input  txclk_en
    );

    // Generator side
    modport slave (
        input  en,
        input  div_wr,
        input  div_wdata,
        input  tx_restart,
        output div_rdata,
        output rxclk_en,
        output txclk_en
    );

endinterface

// File: rtl/uart_baud_gen_frac.sv
// ----------------------------------------------------------------------------
// uart_baud_gen_frac
//
// Purpose:
//   Fractional-N baud tick generator for the UART. From a single clock it
//   produces an oversampled rx tick (OVERSAMPLE ticks per bit) and a 1x tx
//   tick that is phase-locked to the rx tick. The divisor is {int, frac}
//   with FRAC_BITS of fraction; a fractional accumulator stretches some
//   periods by one cycle so that non-integer ratios average out.
//
// Ports:
//   clk        clock
//   reset      asynchronous reset, active high
//   bus        uart_baud_gen_frac_if.slave
//                en          generator enable
//                div_wr      divisor write strobe (writes the shadow)
//                div_wdata   {int, frac} divisor
//                tx_restart  realign tx phase (oversample counter -> 0)
//                div_rdata   active divisor (after clamping)
//                rxclk_en    registered 1-cycle rx tick
//                txclk_en    registered 1-cycle tx tick
// ----------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD_DEFAULT = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_BITS    = 4,
    parameter logic [DIV_WIDTH+FRAC_BITS-1:0] DIV_DEFAULT =
        (DIV_WIDTH+FRAC_BITS)'((64'(CLK_HZ) << FRAC_BITS) /
                               (64'(BAUD_DEFAULT) * 64'(OVERSAMPLE)))
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_baud_gen_frac_if.slave   bus
);

    localparam int DW    = DIV_WIDTH + FRAC_BITS;
    // One extra bit so that int all-ones plus a carry (2^DIV_WIDTH) fits.
    localparam int CNT_W = DIV_WIDTH + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [DW-1:0]        div_active;
    logic [DW-1:0]        div_shadow;
    logic [DW-1:0]        wdata_clamped;
    logic [CNT_W-1:0]     cnt;
    logic [FRAC_BITS-1:0] acc;
    logic [OS_W-1:0]      os_cnt;
    logic                 running;
    logic                 rxclk_en_q;
    logic                 txclk_en_q;

    logic [FRAC_BITS:0]   acc_sum;
    logic [CNT_W-1:0]     period;
    logic [CNT_W-1:0]     cnt_load;
    logic                 tick_due;
    logic                 reload;

    // An integer part below 2 cannot produce a sensible tick train, so it
    // is forced to 2 on the way in; the fraction is kept as written.
    always_comb begin
        wdata_clamped = bus.div_wdata;
        if (bus.div_wdata[DW-1:FRAC_BITS] < DIV_WIDTH'(2)) begin
            wdata_clamped[DW-1:FRAC_BITS] = DIV_WIDTH'(2);
        end
    end

    // The period about to start always comes from the shadow: it holds the
    // latest write, or equals the active divisor when nothing is pending.
    // The accumulator carry stretches this period by one cycle.
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, div_shadow[FRAC_BITS-1:0]};
        period   = {1'b0, div_shadow[DW-1:FRAC_BITS]}
                 + CNT_W'(acc_sum[FRAC_BITS]);
        cnt_load = period - CNT_W'(1);
    end

    // A tick is due when the down-counter has run out while running. The
    // first enabled cycle after en was low reloads without emitting a tick,
    // so the first tick appears one full period after enabling.
    always_comb begin
        tick_due = bus.en && running && (cnt == '0);
        reload   = bus.en && (!running || (cnt == '0));
    end

    // Divisor registers. While stopped, a write takes effect immediately
    // and any pending shadow value is promoted. While running, the active
    // divisor only changes on a reload edge so a period is never cut short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_active <= DIV_DEFAULT;
            div_shadow <= DIV_DEFAULT;
        end else begin
            if (bus.div_wr) begin
                div_shadow <= wdata_clamped;
            end
            if (!bus.en) begin
                div_active <= bus.div_wr ? wdata_clamped : div_shadow;
            end else if (reload) begin
                div_active <= div_shadow;
            end
        end
    end

    // Period counter and fractional accumulator. The accumulator is only
    // cleared by disabling, not by divisor writes, so the fractional phase
    // carries across a divisor change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            acc        <= '0;
            running    <= 1'b0;
            rxclk_en_q <= 1'b0;
        end else if (!bus.en) begin
            cnt        <= '0;
            acc        <= '0;
            running    <= 1'b0;
            rxclk_en_q <= 1'b0;
        end else begin
            running    <= 1'b1;
            rxclk_en_q <= tick_due;
            if (reload) begin
                cnt <= cnt_load;
                acc <= acc_sum[FRAC_BITS-1:0];
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Oversample counter: the tx tick coincides with the rx tick that wraps
    // the counter. A restart on the same edge as an rx tick takes priority,
    // so that rx tick is not counted and no tx tick is emitted for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt     <= '0;
            txclk_en_q <= 1'b0;
        end else if (!bus.en) begin
            os_cnt     <= '0;
            txclk_en_q <= 1'b0;
        end else begin
            txclk_en_q <= 1'b0;
            if (bus.tx_restart) begin
                os_cnt <= '0;
            end else if (tick_due) begin
                if (os_cnt == OS_LAST) begin
                    os_cnt     <= '0;
                    txclk_en_q <= 1'b1;
                end else begin
                    os_cnt <= os_cnt + OS_W'(1);
                end
            end
        end
    end

    assign bus.div_rdata = div_active;
    assign bus.rxclk_en  = rxclk_en_q;
    assign bus.txclk_en  = txclk_en_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// ----------------------------------------------------------------------------
// tb_uart_baud_gen_frac
//
// Scoreboard bench for uart_baud_gen_frac. Each scenario is planned up front:
// a reference model turns the enable window, divisor writes and tx restarts
// into the absolute cycles at which rx/tx ticks must appear and the divisor
// that div_rdata must show after every reload. Those expectations are queued;
// a monitor on the falling edge pops and compares whenever a tick is seen.
// ----------------------------------------------------------------------------
module tb_uart_baud_gen_frac;

    localparam int CLK_HZ    = 50000000;
    localparam int BAUD      = 115200;
    localparam int OS        = 16;
    localparam int DIV_WIDTH = 16;
    localparam int FRAC_BITS = 4;
    localparam int DW        = DIV_WIDTH + FRAC_BITS;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    uart_baud_gen_frac_if #(.DIV_WIDTH(DIV_WIDTH), .FRAC_BITS(FRAC_BITS)) bus ();

    uart_baud_gen_frac #(
        .CLK_HZ      (CLK_HZ),
        .BAUD_DEFAULT(BAUD),
        .OVERSAMPLE  (OS),
        .DIV_WIDTH   (DIV_WIDTH),
        .FRAC_BITS   (FRAC_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [DW-1:0] val; } rd_t;
    typedef struct { int edge_no; logic [DW-1:0] raw; } wr_t;

    int  rx_q[$];
    int  tx_q[$];
    rd_t rd_q[$];

    wr_t wr_list[$];
    int  rs_list[$];
    int  m_rx[$];
    int  m_tx[$];
    rd_t m_rd[$];

    int          sc_e;
    int          sc_x;
    logic [DW-1:0] cur_div;
    logic [DW-1:0] def_div;

    int n_checks = 0;
    int n_errors = 0;
    int mon_t;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [DW-1:0] makeDiv(input int i, input int f);
        return DW'(i * (1 << FRAC_BITS) + f);
    endfunction

    function automatic logic [DW-1:0] clampDiv(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (int'(v[DW-1:FRAC_BITS]) < 2) r = makeDiv(2, int'(v[FRAC_BITS-1:0]));
        return r;
    endfunction

    // Reference model. Reloads happen at the enable edge and at every tick
    // edge; the divisor for a reload is the last write on an earlier edge.
    // Each reload's period is int plus one whenever the running fractional
    // sum overflows. Rx ticks are counted in groups of OS for the tx tick,
    // with a restart zeroing the count and swallowing a coincident tick.
    function automatic void runModel();
        int r, acc, os, t, ip, fp, s;
        bit hit;
        logic [DW-1:0] d;
        m_rx.delete();
        m_tx.delete();
        m_rd.delete();
        r   = sc_e;
        acc = 0;
        os  = 0;
        while (1) begin
            d = cur_div;
            foreach (wr_list[j]) if (wr_list[j].edge_no < r) d = clampDiv(wr_list[j].raw);
            m_rd.push_back('{cyc: r, val: d});
            ip  = int'(d[DW-1:FRAC_BITS]);
            fp  = int'(d[FRAC_BITS-1:0]);
            s   = acc + fp;
            t   = r + ip + (s >= (1 << FRAC_BITS) ? 1 : 0);
            acc = s % (1 << FRAC_BITS);
            if (t >= sc_x) break;
            m_rx.push_back(t);
            hit = 0;
            foreach (rs_list[j]) begin
                if (rs_list[j] > r && rs_list[j] < t) os = 0;
                if (rs_list[j] == t) hit = 1;
            end
            if (hit) begin
                os = 0;
            end else begin
                os++;
                if (os == OS) begin
                    m_tx.push_back(t);
                    os = 0;
                end
            end
            r = t;
        end
    endfunction

    // Monitor: compares every observed tick against the queued expectation
    // and flags ticks that never came.
    always @(negedge clk) begin
        if (bus.rxclk_en === 1'b1) begin
            if (rx_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("[TB] FAIL rx_unexpected: tick at cycle %0d, expected none", cyc);
            end else begin
                mon_t = rx_q.pop_front();
                checkOutput("rx_tick_cycle", cyc, mon_t);
            end
        end else if (rx_q.size() > 0 && rx_q[0] < cyc) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL rx_missed: no tick, expected at cycle %0d", rx_q[0]);
            void'(rx_q.pop_front());
        end
        if (bus.txclk_en === 1'b1) begin
            if (tx_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("[TB] FAIL tx_unexpected: tick at cycle %0d, expected none", cyc);
            end else begin
                mon_t = tx_q.pop_front();
                checkOutput("tx_tick_cycle", cyc, mon_t);
            end
        end else if (tx_q.size() > 0 && tx_q[0] < cyc) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL tx_missed: no tick, expected at cycle %0d", tx_q[0]);
            void'(tx_q.pop_front());
        end
        if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            checkOutput("div_rdata_reload", bus.div_rdata, rd_q[0].val);
            void'(rd_q.pop_front());
        end
    end

    // Divisor write while stopped; the active value must follow promptly.
    task automatic setDiv(input logic [DW-1:0] raw);
        @(negedge clk);
        bus.div_wr    = 1'b1;
        bus.div_wdata = raw;
        @(negedge clk);
        bus.div_wr = 1'b0;
        cur_div    = clampDiv(raw);
        @(negedge clk);
        checkOutput("div_rdata_idle", bus.div_rdata, cur_div);
    endtask

    task automatic planStart(input int len);
        @(negedge clk);
        sc_e = cyc + 2;
        sc_x = sc_e + len;
        wr_list.delete();
        rs_list.delete();
    endtask

    // Queues the model's expectations and drives the planned window.
    // A non-zero rst_at asserts reset just after that cycle's tick.
    task automatic applyStimulus(input int rst_at);
        int nxt;
        foreach (m_rx[j]) if (rst_at == 0 || m_rx[j] <= rst_at) rx_q.push_back(m_rx[j]);
        foreach (m_tx[j]) if (rst_at == 0 || m_tx[j] <= rst_at) tx_q.push_back(m_tx[j]);
        foreach (m_rd[j]) if (rst_at == 0 || m_rd[j].cyc <= rst_at) rd_q.push_back(m_rd[j]);
        while (cyc < sc_x) begin
            nxt = cyc + 1;
            bus.en         = (nxt >= sc_e) && (nxt < sc_x);
            bus.div_wr     = 1'b0;
            bus.tx_restart = 1'b0;
            foreach (wr_list[j]) begin
                if (wr_list[j].edge_no == nxt) begin
                    bus.div_wr    = 1'b1;
                    bus.div_wdata = wr_list[j].raw;
                end
            end
            foreach (rs_list[j]) if (rs_list[j] == nxt) bus.tx_restart = 1'b1;
            if (rst_at != 0 && cyc == rst_at) begin
                #2;
                reset          = 1'b1;
                bus.en         = 1'b0;
                bus.div_wr     = 1'b0;
                bus.tx_restart = 1'b0;
                #1;
                checkOutput("reset_mid_rx", bus.rxclk_en, 0);
                checkOutput("reset_mid_tx", bus.txclk_en, 0);
                checkOutput("reset_mid_rdata", bus.div_rdata, def_div);
                @(negedge clk);
                @(negedge clk);
                reset   = 1'b0;
                cur_div = def_div;
                break;
            end
            @(negedge clk);
        end
        bus.en         = 1'b0;
        bus.div_wr     = 1'b0;
        bus.tx_restart = 1'b0;
        if (rst_at == 0 && wr_list.size() > 0) cur_div = clampDiv(wr_list[wr_list.size()-1].raw);
        repeat (4) @(negedge clk);
        checkOutput("rx_queue_drained", rx_q.size(), 0);
        checkOutput("tx_queue_drained", tx_q.size(), 0);
        checkOutput("rd_queue_drained", rd_q.size(), 0);
        wr_list.delete();
        rs_list.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ed, nw, nr, j, rst_at, txi;
        def_div        = makeDiv(27, 2);
        reset          = 1'b1;
        bus.en         = 1'b0;
        bus.div_wr     = 1'b0;
        bus.div_wdata  = '0;
        bus.tx_restart = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_rx", bus.rxclk_en, 0);
        checkOutput("reset_tx", bus.txclk_en, 0);
        checkOutput("reset_rdata", bus.div_rdata, def_div);
        reset   = 1'b0;
        cur_div = def_div;
        repeat (2) @(negedge clk);
        checkOutput("idle_rdata", bus.div_rdata, def_div);

        $display("[TB] default divisor 27+2/16");
        planStart(1000);
        runModel();
        applyStimulus(0);

        $display("[TB] disabled: no ticks expected");
        repeat (60) @(negedge clk);

        $display("[TB] integer divisor 4");
        setDiv(makeDiv(4, 0));
        planStart(300);
        runModel();
        applyStimulus(0);

        $display("[TB] divisor 4.5");
        setDiv(makeDiv(4, 8));
        planStart(400);
        runModel();
        applyStimulus(0);

        $display("[TB] mid-period write of 10");
        setDiv(makeDiv(4, 0));
        planStart(200);
        runModel();
        wr_list.push_back('{edge_no: m_rx[2] + 2, raw: makeDiv(10, 0)});
        runModel();
        applyStimulus(0);

        $display("[TB] write on reload edge, then two writes in one period");
        setDiv(makeDiv(5, 0));
        planStart(300);
        runModel();
        wr_list.push_back('{edge_no: m_rx[3], raw: makeDiv(7, 0)});
        runModel();
        wr_list.push_back('{edge_no: m_rx[6] + 1, raw: makeDiv(3, 0)});
        wr_list.push_back('{edge_no: m_rx[6] + 3, raw: makeDiv(6, 5)});
        runModel();
        applyStimulus(0);

        $display("[TB] tx restart between ticks and on a tick edge");
        setDiv(makeDiv(3, 0));
        planStart(600);
        runModel();
        txi = 0;
        foreach (m_rx[k]) if (m_rx[k] == m_tx[0]) txi = k;
        rs_list.push_back(m_rx[txi + 3] + 1);
        rs_list.push_back(m_rx[txi + 3 + 16 + 5]);
        runModel();
        applyStimulus(0);

        $display("[TB] clamped divisors");
        setDiv(makeDiv(1, 0));
        checkOutput("clamp_int1", bus.div_rdata, makeDiv(2, 0));
        setDiv(makeDiv(0, 0));
        checkOutput("clamp_int0", bus.div_rdata, makeDiv(2, 0));
        planStart(100);
        runModel();
        applyStimulus(0);

        $display("[TB] randomized scenarios");
        for (int n = 0; n < 10; n++) begin
            setDiv(makeDiv(int'($urandom_range(9, 0)), int'($urandom_range(15, 0))));
            planStart(int'($urandom_range(400, 150)));
            nw = int'($urandom_range(2, 0));
            ed = sc_e;
            for (int w = 0; w < nw; w++) begin
                ed = ed + int'($urandom_range(40, 1));
                if (ed < sc_x)
                    wr_list.push_back('{edge_no: ed,
                        raw: makeDiv(int'($urandom_range(9, 0)), int'($urandom_range(15, 0)))});
            end
            runModel();
            nr = int'($urandom_range(2, 0));
            for (int q = 0; q < nr; q++) begin
                if (m_rx.size() > 0) begin
                    j  = int'($urandom_range(m_rx.size() - 1, 0));
                    ed = m_rx[j] + int'($urandom_range(1, 0));
                    if (ed < sc_x) rs_list.push_back(ed);
                end
            end
            runModel();
            applyStimulus(0);
        end

        $display("[TB] reset asserted mid-period");
        setDiv(makeDiv(4, 3));
        planStart(400);
        runModel();
        rst_at = (m_tx.size() >= 2) ? m_tx[1] : m_rx[m_rx.size() - 1];
        applyStimulus(rst_at);
        repeat (30) @(negedge clk);
        checkOutput("post_reset_rdata", bus.div_rdata, def_div);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
